// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the multicycle sequencer: state encodings and the default halt target.
// FETCH/EXEC1/EXEC2 encodings match the control decoder; HALTED takes the spare code.
package cpu_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t FETCH  = 2'd0;
    localparam state_t EXEC1  = 2'd1;
    localparam state_t EXEC2  = 2'd2;
    localparam state_t HALTED = 2'd3;

    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/seq_perf_counters.sv
// Retired-instruction and active-cycle counters; one cycle of latency, both wrap at 2^32.
// No backpressure: counts whatever the sequencer reports each cycle.
module seq_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire_i,
    input  logic        active_i,
    output logic [31:0] instr_count_o,
    output logic [31:0] cycle_count_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        instr_d = instr_q;
        cycle_d = cycle_q;
        if (retire_i) instr_d = instr_q + 32'd1;
        if (active_i) cycle_d = cycle_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            instr_q <= instr_d;
            cycle_q <= cycle_d;
        end
    end

    assign instr_count_o = instr_q;
    assign cycle_count_o = cycle_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/EXEC1/EXEC2 sequencer with bus stall, delay-slot-aware halt detection and stall watchdog.
// Stall is same-cycle combinational from waitrequest; state advances one step per unstalled edge.
// Optional perf counters are built only when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR        = HALT_ADDR_DEFAULT,
    parameter int          MAX_STALL_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic        waitrequest_i,
    input  logic        branch_i,
    input  logic [31:0] target_i,
    output state_t      state_o,
    output logic        stall_o,
    output logic        active_o,
    output logic        error_o,
    output logic [31:0] instr_count_o,
    output logic [31:0] cycle_count_o
);

    localparam int WD_W = (MAX_STALL_CYCLES > 0) ? $clog2(MAX_STALL_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL_CYCLES);

    state_t            state_q, state_d;
    logic              in_ds_q, in_ds_d;
    logic              arm_q, arm_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              wd_fire;
    logic              stall;
    logic              retire;

    assign stall  = mem_req_i & waitrequest_i & (state_q != HALTED);
    assign retire = (state_q == EXEC2) & ~stall;

    // Counter saturates at the limit; the limit being reached is what trips the halt.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_fire  = 1'b0;
        if (MAX_STALL_CYCLES > 0) begin
            if (stall) begin
                if (wd_cnt_q != WD_LIMIT) wd_cnt_d = wd_cnt_q + 1'b1;
                wd_fire = (wd_cnt_d == WD_LIMIT);
            end else begin
                wd_cnt_d = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        in_ds_d = in_ds_q;
        arm_d   = arm_q;
        err_d   = err_q;
        if (!stall) begin
            case (state_q)
                FETCH: state_d = EXEC1;
                EXEC1: state_d = EXEC2;
                EXEC2: begin
                    // The halt decision uses the arm left by the previous branch; a branch
                    // sitting in this delay slot then re-arms from its own target.
                    state_d = (in_ds_q & arm_q) ? HALTED : FETCH;
                    in_ds_d = branch_i;
                    arm_d   = branch_i & (target_i == HALT_ADDR);
                end
                default: state_d = state_q;
            endcase
        end
        if (wd_fire) begin
            state_d = HALTED;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            in_ds_q  <= 1'b0;
            arm_q    <= 1'b0;
            err_q    <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            in_ds_q  <= in_ds_d;
            arm_q    <= arm_d;
            err_q    <= err_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign state_o  = state_q;
    assign stall_o  = stall;
    assign active_o = (state_q != HALTED);
    assign error_o  = err_q;

`ifdef SEQ_PERF_CNT_EN
    seq_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .retire_i      (retire),
        .active_i      (active_o),
        .instr_count_o (instr_count_o),
        .cycle_count_o (cycle_count_o)
    );
`else
    assign instr_count_o = 32'h0;
    assign cycle_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: each stimulus cycle queues its hand-derived expected outputs; a negedge monitor compares.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        waitreq;
    logic        branch;
    logic [31:0] target;
    state_t      state;
    logic        stall;
    logic        active;
    logic        error;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;

    cpu_sequencer #(
        .HALT_ADDR        (32'h0000_0000),
        .MAX_STALL_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req_i     (mem_req),
        .waitrequest_i (waitreq),
        .branch_i      (branch),
        .target_i      (target),
        .state_o       (state),
        .stall_o       (stall),
        .active_o      (active),
        .error_o       (error),
        .instr_count_o (instr_count),
        .cycle_count_o (cycle_count)
    );

    typedef struct {
        int          id;
        state_t      st;
        logic        stall;
        logic        act;
        logic        err;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          step_id  = 0;
    logic [31:0] m_ic     = 0;
    logic [31:0] m_cc     = 0;
    bit          perf_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%08h want=0x%08h", nm, id, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state",  e.id, 32'(state),  32'(e.st));
            chk("stall",  e.id, 32'(stall),  32'(e.stall));
            chk("active", e.id, 32'(active), 32'(e.act));
            chk("error",  e.id, 32'(error),  32'(e.err));
            chk("instr_count", e.id, instr_count, e.ic);
            chk("cycle_count", e.id, cycle_count, e.cc);
        end
    end

    // One clock cycle: drive inputs, queue what the outputs must show during this cycle.
    task automatic step(input logic rst, input logic mreq, input logic wreq, input logic br,
                        input logic [31:0] tgt, input state_t est, input logic estall, input logic eerr);
        exp_t e;
        rst_n   = rst;
        mem_req = mreq;
        waitreq = wreq;
        branch  = br;
        target  = tgt;
        if (!rst) begin
            m_ic = 0;
            m_cc = 0;
        end
        e.id    = step_id;
        e.st    = est;
        e.stall = estall;
        e.act   = (est != HALTED);
        e.err   = eerr;
        e.ic    = perf_en ? m_ic : 32'h0;
        e.cc    = perf_en ? m_cc : 32'h0;
        exp_q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        if (rst) begin
            if (est != HALTED) m_cc++;
            if (est == EXEC2 && !estall) m_ic++;
        end
    endtask

    task automatic instr3(input logic br, input logic [31:0] tgt);
        step(1, 1, 0, 0, 0, FETCH, 0, 0);
        step(1, 0, 0, 0, 0, EXEC1, 0, 0);
        step(1, 0, 0, br, tgt, EXEC2, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, FETCH, 0, 0);
        step(0, 0, 0, 0, 0, FETCH, 0, 0);
    endtask

    initial begin
`ifdef SEQ_PERF_CNT_EN
        perf_en = 1'b1;
`else
        perf_en = 1'b0;
`endif
        rst_n = 1'b0; mem_req = 1'b0; waitreq = 1'b0; branch = 1'b0; target = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        // Straight-line stream; a branch strobe outside EXEC2 must be ignored.
        step(1, 1, 0, 1, 32'h0, FETCH, 0, 0);
        step(1, 0, 0, 1, 32'h0, EXEC1, 0, 0);
        step(1, 0, 0, 0, 32'h0, EXEC2, 0, 0);
        instr3(0, 32'h0);
        instr3(0, 32'h0);

        // Four waitrequest cycles in FETCH, then a stalled EXEC2 whose branch must not arm.
        repeat (4) step(1, 1, 1, 0, 0, FETCH, 1, 0);
        step(1, 1, 0, 0, 0, FETCH, 0, 0);
        step(1, 0, 0, 0, 0, EXEC1, 0, 0);
        step(1, 1, 1, 1, 32'h0, EXEC2, 1, 0);
        step(1, 1, 1, 1, 32'h0, EXEC2, 1, 0);
        step(1, 0, 0, 0, 32'h0, EXEC2, 0, 0);
        instr3(0, 32'h0);
        instr3(0, 32'h0);

        // JR to 0 then delay-slot ADDIU: halt only after the delay slot retires.
        instr3(1, 32'h0);
        instr3(0, 32'h0);
        repeat (3) step(1, 1, 1, 1, 32'h0, HALTED, 0, 0);
        do_reset();

        // BEQ to 0x1000 with J to 0 in its slot: halt after the J's own delay slot.
        instr3(1, 32'h0000_1000);
        instr3(1, 32'h0);
        instr3(0, 32'h0);
        repeat (2) step(1, 0, 0, 0, 32'h0, HALTED, 0, 0);
        do_reset();

        // Seven stall cycles stay under the watchdog limit.
        repeat (7) step(1, 1, 1, 0, 0, FETCH, 1, 0);
        step(1, 1, 0, 0, 0, FETCH, 0, 0);
        step(1, 0, 0, 0, 0, EXEC1, 0, 0);

        // Reset asserted while EXEC2 is stalled: FETCH immediately, counters cleared.
        step(1, 1, 1, 0, 0, EXEC2, 1, 0);
        step(1, 1, 1, 0, 0, EXEC2, 1, 0);
        do_reset();

        // Eight consecutive stalls trip the watchdog: sticky error and HALTED.
        repeat (8) step(1, 1, 1, 0, 0, FETCH, 1, 0);
        repeat (3) step(1, 1, 1, 1, 32'h0, HALTED, 0, 1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
